// File: rtl/fetch_ctrl.sv
// fetch_ctrl
//   Instruction fetch controller. It issues one request at a time to
//   instruction memory, presents fetched words in a single output slot,
//   absorbs one extra word in a skid buffer when downstream stalls, and
//   redirects on branch_taken. A request that is still outstanding when
//   a branch arrives is allowed to finish, and its data is then discarded.
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous, active-high reset
//   freeze          downstream stall; the output slot is not consumed
//   branch_taken    redirect fetch to branch_address and flush
//   branch_address  redirect target (the low two bits are ignored)
//   mem_ready       memory completes the outstanding request this cycle
//   mem_rdata       instruction word, valid when mem_ready=1
//   mem_req         a request to memory is outstanding
//   mem_addr        registered request address
//   pc_out          address of the slot instruction + 4
//   instruction_out instruction word in the slot
//   valid_out       the slot holds a valid instruction
module fetch_ctrl #(
    parameter int ADDRESS_LEN = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [ADDRESS_LEN-1:0] branch_address,
    input  logic                   mem_ready,
    input  logic [ADDRESS_LEN-1:0] mem_rdata,
    output logic                   mem_req,
    output logic [ADDRESS_LEN-1:0] mem_addr,
    output logic [ADDRESS_LEN-1:0] pc_out,
    output logic [ADDRESS_LEN-1:0] instruction_out,
    output logic                   valid_out
);

    // FETCH: request outstanding, its data is wanted
    // DROP : request outstanding, its data belongs to a flushed path
    // HOLD : slot and skid both full, no request issued
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_DROP  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [ADDRESS_LEN-1:0] PC_STEP = ADDRESS_LEN'(4);

    logic [1:0]             state_q,      state_d;
    logic [ADDRESS_LEN-1:0] fetch_pc_q,   fetch_pc_d;
    logic [ADDRESS_LEN-1:0] req_addr_q,   req_addr_d;
    logic                   valid_q,      valid_d;
    logic [ADDRESS_LEN-1:0] instr_q,      instr_d;
    logic [ADDRESS_LEN-1:0] pc_q,         pc_d;
    logic [ADDRESS_LEN-1:0] skid_instr_q, skid_instr_d;
    logic [ADDRESS_LEN-1:0] skid_pc_q,    skid_pc_d;

    logic                   slot_free;
    logic                   slot_consumed;
    logic [ADDRESS_LEN-1:0] fetch_pc_inc;
    logic [ADDRESS_LEN-1:0] req_addr_inc;
    logic [ADDRESS_LEN-1:0] branch_target;
    logic                   unused_branch_lsbs;

    assign slot_free     = !valid_q || !freeze;
    assign slot_consumed = valid_q && !freeze;
    assign fetch_pc_inc  = fetch_pc_q + PC_STEP;
    assign req_addr_inc  = req_addr_q + PC_STEP;
    assign branch_target = {branch_address[ADDRESS_LEN-1:2], 2'b00};
    assign unused_branch_lsbs = ^branch_address[1:0];

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_addr_d   = req_addr_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        if (branch_taken) begin
            // Branch wins over freeze and over any returning data.
            valid_d      = 1'b0;
            skid_instr_d = '0;
            skid_pc_d    = '0;
            fetch_pc_d   = branch_target;
            if (state_q == ST_HOLD || mem_ready) begin
                state_d    = ST_FETCH;
                req_addr_d = branch_target;
            end else begin
                // Outstanding request must still complete on the old address.
                state_d = ST_DROP;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ready) begin
                        fetch_pc_d = fetch_pc_inc;
                        if (slot_free) begin
                            valid_d    = 1'b1;
                            instr_d    = mem_rdata;
                            pc_d       = req_addr_inc;
                            req_addr_d = fetch_pc_inc;
                        end else begin
                            // Slot stalled: park the word and stop requesting.
                            skid_instr_d = mem_rdata;
                            skid_pc_d    = req_addr_inc;
                            state_d      = ST_HOLD;
                        end
                    end else if (slot_consumed) begin
                        valid_d = 1'b0;
                    end
                end
                ST_DROP: begin
                    if (slot_consumed) begin
                        valid_d = 1'b0;
                    end
                    if (mem_ready) begin
                        req_addr_d = fetch_pc_q;
                        state_d    = ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (!freeze) begin
                        valid_d    = 1'b1;
                        instr_d    = skid_instr_q;
                        pc_d       = skid_pc_q;
                        req_addr_d = fetch_pc_q;
                        state_d    = ST_FETCH;
                    end
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            fetch_pc_q   <= '0;
            req_addr_q   <= '0;
            valid_q      <= 1'b0;
            instr_q      <= '0;
            pc_q         <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_addr_q   <= req_addr_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    // Request is dropped combinationally during reset so memory never
    // sees a stale address while the registers are being cleared.
    assign mem_req         = !rst && (state_q != ST_HOLD);
    assign mem_addr        = req_addr_q;
    assign pc_out          = pc_q;
    assign instruction_out = instr_q;
    assign valid_out       = valid_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam int AL = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          freeze;
    logic          branch_taken;
    logic [AL-1:0] branch_address;
    logic          mem_ready;
    logic [AL-1:0] mem_rdata;
    logic          mem_req;
    logic [AL-1:0] mem_addr;
    logic [AL-1:0] pc_out;
    logic [AL-1:0] instruction_out;
    logic          valid_out;

    always #5 clk = ~clk;

    fetch_ctrl #(.ADDRESS_LEN(AL)) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_address  (branch_address),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned n_consumed = 0;

    // Start address of each new instruction stream (reset or branch),
    // pushed by stimulus, popped by the monitor when the event takes effect.
    logic [31:0] seg_q[$];

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] align4(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the current negedge, then advance to the
    // next negedge so outputs reflect the intervening rising edge.
    task automatic cyc(input logic r, input logic fz, input logic br,
                       input logic [31:0] ba, input logic rdy);
        rst            = r;
        freeze         = fz;
        branch_taken   = br;
        branch_address = ba;
        mem_ready      = rdy;
        mem_rdata      = rdy ? word_at(mem_addr) : $urandom;
        if (r) seg_q.push_back(32'h0);
        else if (br) seg_q.push_back(align4(ba));
        @(negedge clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] mon_exp_pc    = 32'h0;
    logic        mon_prev_rst  = 1'b1;
    logic        mon_prev_pend = 1'b0;
    logic [31:0] mon_prev_addr = 32'h0;
    int          mon_idle      = 0;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_prev_rst) begin
                check_bit("reset_valid", valid_out, 1'b0);
                check("reset_pc", pc_out, 32'h0);
                check("reset_instr", instruction_out, 32'h0);
                check("reset_addr", mem_addr, 32'h0);
            end
            if (rst) begin
                check_bit("req_in_reset", mem_req, 1'b0);
                if (seg_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL seg_queue: got empty expected reset entry");
                end else begin
                    mon_exp_pc = seg_q.pop_front();
                end
                mon_idle = 0;
            end else begin
                if (mon_prev_pend) check("addr_stable", mem_addr, mon_prev_addr);
                if (valid_out && !freeze) begin
                    check("stream_pc", pc_out, mon_exp_pc + 32'd4);
                    check("stream_instr", instruction_out, word_at(mon_exp_pc));
                    mon_exp_pc = mon_exp_pc + 32'd4;
                    n_consumed++;
                    mon_idle = 0;
                end else begin
                    mon_idle++;
                end
                if (mon_idle > 300) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL progress: got %0d idle cycles expected <= 300", mon_idle);
                    mon_idle = 0;
                end
                if (branch_taken) begin
                    if (seg_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL seg_queue: got empty expected branch entry");
                    end else begin
                        mon_exp_pc = seg_q.pop_front();
                    end
                end
            end
            mon_prev_rst  = rst;
            mon_prev_pend = !rst && mem_req && !mem_ready;
            mon_prev_addr = mem_addr;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0;
        branch_address = '0; mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check_bit("d_req_rst", mem_req, 1'b0);

        // Zero-wait streaming from reset
        for (int i = 0; i < 4; i++) begin
            check("d_seq_addr", mem_addr, 32'(4 * i));
            cyc(0, 0, 0, 0, 1);
            check_bit("d_seq_valid", valid_out, 1'b1);
            check("d_seq_pc", pc_out, 32'(4 * (i + 1)));
            check("d_seq_instr", instruction_out, word_at(32'(4 * i)));
        end

        // Freeze for 3 cycles with memory ready: one word to skid
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 1);
            check_bit("d_hold_req", mem_req, 1'b0);
            check_bit("d_hold_valid", valid_out, 1'b1);
            check("d_hold_pc", pc_out, 32'd16);
            check("d_hold_addr", mem_addr, 32'd16);
        end
        cyc(0, 0, 0, 0, 1);
        check("d_skid_pc", pc_out, 32'd20);
        check("d_skid_instr", instruction_out, word_at(32'd16));
        check("d_skid_addr", mem_addr, 32'd20);
        check_bit("d_skid_req", mem_req, 1'b1);
        cyc(0, 0, 0, 0, 1);
        check("d_after_skid_pc", pc_out, 32'd24);
        check("d_after_skid_addr", mem_addr, 32'd24);

        // Branch while request outstanding -> DROP
        cyc(0, 0, 1, 32'h10, 1);
        check_bit("d_br_valid", valid_out, 1'b0);
        check("d_br_addr", mem_addr, 32'h10);
        cyc(0, 0, 1, 32'h103, 0);
        check("d_drop_addr", mem_addr, 32'h10);
        check_bit("d_drop_req", mem_req, 1'b1);
        check_bit("d_drop_valid", valid_out, 1'b0);
        cyc(0, 0, 0, 0, 0);
        check("d_drop_addr2", mem_addr, 32'h10);
        check_bit("d_drop_valid2", valid_out, 1'b0);
        cyc(0, 0, 0, 0, 1);
        check_bit("d_drop_discard", valid_out, 1'b0);
        check("d_drop_next", mem_addr, 32'h100);
        cyc(0, 0, 0, 0, 1);
        check_bit("d_tgt_valid", valid_out, 1'b1);
        check("d_tgt_pc", pc_out, 32'h104);
        check("d_tgt_instr", instruction_out, word_at(32'h100));

        // Branch in HOLD together with freeze and mem_ready
        cyc(0, 1, 0, 0, 1);
        check_bit("d_hold2_req", mem_req, 1'b0);
        cyc(0, 1, 1, 32'h2000, 1);
        check_bit("d_holdbr_valid", valid_out, 1'b0);
        check("d_holdbr_addr", mem_addr, 32'h2000);
        check_bit("d_holdbr_req", mem_req, 1'b1);
        cyc(0, 0, 0, 0, 1);
        check("d_holdbr_pc", pc_out, 32'h2004);
        check("d_holdbr_instr", instruction_out, word_at(32'h2000));

        // Address wrap (target also exercises alignment)
        cyc(0, 0, 1, 32'hFFFF_FFFE, 1);
        check("d_wrap_addr", mem_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 1);
        check_bit("d_wrap_valid", valid_out, 1'b1);
        check("d_wrap_pc", pc_out, 32'h0);
        check("d_wrap_instr", instruction_out, word_at(32'hFFFF_FFFC));
        check("d_wrap_next", mem_addr, 32'h0);
        cyc(0, 0, 0, 0, 1);
        check("d_wrap_addr2", mem_addr, 32'h4);

        // Reset while in DROP with a request outstanding
        cyc(0, 0, 1, 32'h40, 0);
        check("d_rd_addr", mem_addr, 32'h4);
        check_bit("d_rd_req", mem_req, 1'b1);
        cyc(1, 0, 0, 0, 1);
        check_bit("d_rd_valid", valid_out, 1'b0);
        check_bit("d_rd_req_rst", mem_req, 1'b0);
        check("d_rd_addr_rst", mem_addr, 32'h0);
        cyc(0, 0, 0, 0, 0);
        check_bit("d_rd_req_after", mem_req, 1'b1);
        check("d_rd_addr_after", mem_addr, 32'h0);
        cyc(0, 0, 0, 0, 1);
        check("d_rd_pc_after", pc_out, 32'h4);
        check("d_rd_instr_after", instruction_out, word_at(32'h0));

        // Randomised traffic, checked by the monitor
        for (int i = 0; i < 3000; i++) begin
            logic        r, fz, br, rdy;
            logic [31:0] ba;
            r   = ($urandom_range(199) == 0);
            fz  = ($urandom_range(9) < 3);
            br  = ($urandom_range(19) == 0);
            rdy = ($urandom_range(9) < 7);
            case ($urandom_range(3))
                0:       ba = $urandom;
                1:       ba = 32'hFFFF_FFF0 + 32'($urandom_range(15));
                default: ba = 32'($urandom_range(1023));
            endcase
            cyc(r, fz, br, ba, rdy);
        end
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1);

        check_bit("stream_progress", n_consumed > 500, 1'b1);
        check("seg_queue_drained", 32'(seg_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
